sdram_bist: RTL and testbench
=============================

# sdram_bist

Built-in self-test initiator for the SDRAM front-end user port. It drives the streaming-write, single-read and single-write handshakes from the master side. It fills a region with an address-derived pattern, reads every word back, and reports mismatches. It sits between the board-level test control (key/UART) and the SDRAM front-end, on the front-end's user clock `clk`.

## Interface
Parameters:
- `BASE` = 24'h000000: first word address of the test region; bits [2:0] must be 0.
- `LEN_LOG2` = 10: region size is 2^LEN_LOG2 words; legal range 3..24.
- `GAP` = 32: idle cycles inserted after each 8-word streaming group, so the front-end back buffer can flush.
- `TIMEOUT` = 4095: maximum cycles to wait for `read_ack`. Used only with `SDRAM_BIST_TIMEOUT_EN`.

Ports:
- `clk` in 1: user-port clock; the front-end samples on this same edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `start` in 1: rising edge starts a run when idle.
- `seed` in 16: pattern seed; latched on accepted `start`.
- `busy` out 1: run in progress.
- `done` out 1: high from run end until next accepted `start`.
- `pass` out 1: `done` && `err_count`==0 && !`timeout`.
- `timeout` out 1: a read timed out in the last run.
- `err_count` out 16: mismatch count; saturates at 16'hFFFF.
- `first_err_addr` out 24: address of the first mismatch.
- `first_err_data` out 16: data read at the first mismatch.
- `address` out 24: user-port address.
- `data_in` out 16: user-port write data.
- `write_latch_address` out 1: latch the streaming start address.
- `write_en` out 1: streaming write strobe, one word per cycle.
- `write_req` out 1: single-word write request; unused by the fill, held 0.
- `write_ack` in 1: single-write acknowledge; ignored.
- `read_req` out 1: read request.
- `read_ack` in 1: read acknowledge; `data_out` is valid while it is high.
- `data_out` in 16: read data.

## Operation
- Pattern: expected(a) = a[15:0] ^ seed_q.
- The word counter `idx` is LEN_LOG2+1 bits wide. `address` = BASE + idx, truncated to 24 bits.
- FSM states:
  - IDLE: a `start` rising edge loads seed_q and clears `err_count`, `first_err_*`, `timeout` and `done`. Sets `busy` and goes to FILL.
  - FILL: asserts `write_en` with `data_in`=expected(`address`) and increments `idx`. `write_latch_address`=1 only when idx==0. When idx[2:0]==7, goes to GAP.
  - GAP: all strobes 0 for `GAP` cycles. Then goes to FILL if words remain; otherwise clears `idx` and goes to RREQ.
  - RREQ: asserts `read_req` and goes to RWAIT.
  - RWAIT: holds `read_req` and `address`. When `read_ack`=1:
    - compares `data_out` to the expected value;
    - on mismatch, increments `err_count` (saturating) and captures `first_err_*` only if `err_count` was 0;
    - deasserts `read_req` and goes to RREL.
  - RREL: `read_req`=0 until `read_ack`=0. This guarantees a fresh rising edge for the next read. Then goes to RREQ with idx+1, or to FIN after the last word.
  - FIN: `busy`=0, `done`=1. Returns to IDLE; results hold.
- A `start` while `busy` is ignored.
- `write_en` and `read_req` are never high in the same cycle.
- A reset mid-run aborts immediately: no partial-group completion and no further strobes.

## Timing
- Reset values:
  - all outputs 0;
  - internal state: FSM IDLE, `idx` 0, seed_q 0.
- All outputs are registered.
- `start` edge to first `write_en`: 2 cycles.
- Fill duration: 2^LEN_LOG2 strobe cycles plus (2^LEN_LOG2/8)·GAP idle cycles.
- Read issue: `read_req` rises 1 cycle after entering RREQ.
- Read compare: happens in the cycle `read_ack` is sampled high; `err_count` updates the next cycle.
- Minimum per-read cost: 3 cycles plus responder latency. A cached-line hit in the front-end returns `read_ack` 1 cycle after the `read_req` edge.
- `done` rises 1 cycle after the final RREL exit.

## Configuration
- Macro: `SDRAM_BIST_TIMEOUT_EN`.
- Defined: a 12-bit-or-wider counter runs in RWAIT. On reaching `TIMEOUT` with no `read_ack`:
  - `timeout`=1 and `err_count`+1;
  - `read_req`=0, then go to FIN (abort, `pass`=0).
- Undefined: there is no counter, RWAIT waits indefinitely, and `timeout` is tied to 0.

## Test plan
All scenarios use a behavioural front-end model.
- **Clean run:** LEN_LOG2=4, BASE=0, seed=0.
  - Expect exactly 16 `write_en` cycles in two groups of 8, separated by 32 idle cycles.
  - `write_latch_address` pulses once, with address 0.
  - Then 16 read handshakes; `done`=1, `pass`=1, `err_count`=0.
- **Seed pattern:** seed=16'hA5A5 → `data_in` at address 24'h000003 is 16'hA5A6.
- **Corruption:** the model XORs bit 0 at address 5 → `err_count`=1, `first_err_addr`=24'h000005, `first_err_data`=16'h0004, `pass`=0.
- **Start while busy:** a `start` pulse during RWAIT → no restart, `idx` continues, and the final results are unchanged.
- **Timeout:** the model never acks the third read.
  - With the macro: `timeout`=1 after 4095 cycles, `done`=1, `err_count`=1.
  - Without the macro: `busy` stays 1.
- **Reset mid-run:** `sys_rst_n` low during FILL → all outputs 0 immediately. A later `start` completes a clean run with `pass`=1.

Source files
------------

// File: rtl/sdram_bist.sv
// Built-in self-test initiator for the SDRAM front-end user port: fills a region with
// an address-derived pattern, reads it back and counts mismatches. Option: SDRAM_BIST_TIMEOUT_EN.
module sdram_bist #(
    parameter logic [23:0] BASE     = 24'h000000,
    parameter int unsigned LEN_LOG2 = 10,
    parameter int unsigned GAP      = 32,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [15:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [23:0] first_err_addr,
    output logic [15:0] first_err_data,
    output logic [23:0] address,
    output logic [15:0] data_in,
    output logic        write_latch_address,
    output logic        write_en,
    output logic        write_req,
    input  logic        write_ack,
    output logic        read_req,
    input  logic        read_ack,
    input  logic [15:0] data_out
);

    localparam int unsigned IDX_W = LEN_LOG2 + 1;
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((64'd1 << LEN_LOG2) - 64'd1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GAP,
        S_RREQ,
        S_RWAIT,
        S_RREL,
        S_FIN
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [15:0]      seed_q, seed_d;
    logic             start_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      err_count_q, err_count_d;
    logic [23:0]      first_err_addr_q, first_err_addr_d;
    logic [15:0]      first_err_data_q, first_err_data_d;
    logic [23:0]      address_q, address_d;
    logic [15:0]      data_in_q, data_in_d;
    logic             wla_q, wla_d;
    logic             write_en_q, write_en_d;
    logic             read_req_q, read_req_d;
    logic [23:0]      addr_c;
    logic [15:0]      exp_c;
    logic             unused_c;

`ifdef SDRAM_BIST_TIMEOUT_EN
    localparam int unsigned TMO_W = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // RWAIT watchdog counter
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign unused_c = write_ack;
`else
    assign unused_c = ^{write_ack, 32'(TIMEOUT)};
`endif

    // word address and the pattern expected at the currently driven address
    assign addr_c = 24'(32'(BASE) + 32'(idx_q));
    assign exp_c  = address_q[15:0] ^ seed_q;

    always_comb begin
        state_d          = state_q;
        idx_d            = idx_q;
        gap_cnt_d        = gap_cnt_q;
        seed_d           = seed_q;
        busy_d           = busy_q;
        done_d           = done_q;
        pass_d           = pass_q;
        timeout_d        = timeout_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        address_d        = address_q;
        data_in_d        = data_in_q;
        wla_d            = 1'b0;
        write_en_d       = 1'b0;
        read_req_d       = 1'b0;
`ifdef SDRAM_BIST_TIMEOUT_EN
        tmo_cnt_d        = tmo_cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    seed_d           = seed;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    first_err_data_d = '0;
                    timeout_d        = 1'b0;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    busy_d           = 1'b1;
                    idx_d            = '0;
                    state_d          = S_FILL;
                end
            end
            S_FILL: begin
                write_en_d = 1'b1;
                wla_d      = (idx_q == '0);
                address_d  = addr_c;
                data_in_d  = addr_c[15:0] ^ seed_q;
                idx_d      = idx_q + IDX_W'(1);
                if (idx_q[2:0] == 3'd7) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + GAP_W'(1);
                if (gap_cnt_q == GAP_LAST) begin
                    if (idx_q[LEN_LOG2]) begin
                        idx_d   = '0;
                        state_d = S_RREQ;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_RREQ: begin
                read_req_d = 1'b1;
                address_d  = addr_c;
`ifdef SDRAM_BIST_TIMEOUT_EN
                tmo_cnt_d  = '0;
`endif
                state_d    = S_RWAIT;
            end
            S_RWAIT: begin
                read_req_d = 1'b1;
                if (read_ack) begin
                    // first_err_* only captures while the count is still zero
                    if (data_out != exp_c) begin
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                        if (err_count_q == 16'd0) begin
                            first_err_addr_d = address_q;
                            first_err_data_d = data_out;
                        end
                    end
                    read_req_d = 1'b0;
                    state_d    = S_RREL;
                end
`ifdef SDRAM_BIST_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d  = 1'b1;
                    if (err_count_q != 16'hFFFF) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    read_req_d = 1'b0;
                    state_d    = S_FIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
            end
            S_RREL: begin
                // wait for ack to drop so the next request is a fresh edge
                if (!read_ack) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_RREQ;
                    end
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_count_q == 16'd0) && !timeout_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            gap_cnt_q        <= '0;
            seed_q           <= '0;
            start_q          <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            timeout_q        <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            address_q        <= '0;
            data_in_q        <= '0;
            wla_q            <= 1'b0;
            write_en_q       <= 1'b0;
            read_req_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            gap_cnt_q        <= gap_cnt_d;
            seed_q           <= seed_d;
            start_q          <= start;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            timeout_q        <= timeout_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            address_q        <= address_d;
            data_in_q        <= data_in_d;
            wla_q            <= wla_d;
            write_en_q       <= write_en_d;
            read_req_q       <= read_req_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign timeout             = timeout_q;
    assign err_count           = err_count_q;
    assign first_err_addr      = first_err_addr_q;
    assign first_err_data      = first_err_data_q;
    assign address             = address_q;
    assign data_in             = data_in_q;
    assign write_latch_address = wla_q;
    assign write_en            = write_en_q;
    assign read_req            = read_req_q;
    assign write_req           = 1'b0;

endmodule

// File: tb/tb_sdram_bist.sv
// Directed self-checking bench for sdram_bist with a behavioural front-end responder.
module tb_sdram_bist;

    localparam int unsigned GAP = 32;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [15:0] seed;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [23:0] first_err_addr;
    logic [15:0] first_err_data;
    logic [23:0] address;
    logic [15:0] data_in;
    logic        write_latch_address, write_en, write_req;
    logic        write_ack;
    logic        read_req;
    logic        read_ack;
    logic [15:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    // responder / monitor state
    logic [15:0] mem [16];
    logic [23:0] wptr;
    logic [23:0] latch_addr;
    logic [15:0] data_at3;
    logic        corrupt, hang_third, prev_we;
    int          cyc, last_we, n_wr, n_rd, n_latch, n_gaps, gap_val, overlap;

    sdram_bist #(.BASE(24'h000000), .LEN_LOG2(4), .GAP(GAP), .TIMEOUT(4095)) dut (
        .clk                (clk),
        .sys_rst_n          (sys_rst_n),
        .start              (start),
        .seed               (seed),
        .busy               (busy),
        .done               (done),
        .pass               (pass),
        .timeout            (timeout),
        .err_count          (err_count),
        .first_err_addr     (first_err_addr),
        .first_err_data     (first_err_data),
        .address            (address),
        .data_in            (data_in),
        .write_latch_address(write_latch_address),
        .write_en           (write_en),
        .write_req          (write_req),
        .write_ack          (write_ack),
        .read_req           (read_req),
        .read_ack           (read_ack),
        .data_out           (data_out)
    );

    always #5 clk = ~clk;

    // front-end model: streaming writes into mem, single reads acked one cycle after request
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (write_en && read_req) overlap = overlap + 1;
        if (write_en) begin
            if (write_latch_address) begin
                n_latch    = n_latch + 1;
                latch_addr = address;
                wptr       = address;
            end
            mem[wptr[3:0]] = data_in;
            if (wptr == 24'd3) data_at3 = data_in;
            if (n_wr > 0 && !prev_we) begin
                n_gaps  = n_gaps + 1;
                gap_val = cyc - last_we - 1;
            end
            wptr    = wptr + 24'd1;
            n_wr    = n_wr + 1;
            last_we = cyc;
        end
        prev_we = write_en;
        if (!read_req) begin
            read_ack = 1'b0;
        end else if (!read_ack && !(hang_third && n_rd == 2)) begin
            read_ack = 1'b1;
            data_out = mem[address[3:0]] ^ ((corrupt && address == 24'd5) ? 16'h0001 : 16'h0000);
            n_rd     = n_rd + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_wr = 0; n_rd = 0; n_latch = 0; n_gaps = 0; gap_val = 0; overlap = 0;
        latch_addr = 24'hFFFFFF; data_at3 = 16'h0000; prev_we = 1'b0; last_we = 0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) check("done_wait", 32'(done), 32'd1);
    endtask

    task automatic run_seed(input logic [15:0] s);
        clear_stats();
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
    endtask

    initial begin
        cyc = 0; read_ack = 1'b0; data_out = 16'h0000; wptr = '0;
        corrupt = 1'b0; hang_third = 1'b0; write_ack = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        clear_stats();
        sys_rst_n = 1'b0; start = 1'b0; seed = 16'h0000;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_ferr", {first_err_data, 8'h00, first_err_addr[7:0]}, 32'd0);
        check("rst_addr", 32'(address), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_strobes", {28'd0, write_en, write_latch_address, write_req, read_req}, 32'd0);
        sys_rst_n = 1'b1;
        @(negedge clk);

        // clean run with start-to-write_en latency
        clear_stats();
        seed  = 16'h0000;
        start = 1'b1;
        @(posedge clk); #1;
        check("lat1_we", 32'(write_en), 32'd0);
        check("lat1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("lat2_we", 32'(write_en), 32'd1);
        check("lat2_wla", 32'(write_latch_address), 32'd1);
        check("lat2_addr", 32'(address), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        check("clean_writes", 32'(n_wr), 32'd16);
        check("clean_gaps", 32'(n_gaps), 32'd1);
        check("clean_gap_len", 32'(gap_val), 32'(GAP));
        check("clean_latch_n", 32'(n_latch), 32'd1);
        check("clean_latch_addr", 32'(latch_addr), 32'd0);
        check("clean_reads", 32'(n_rd), 32'd16);
        check("clean_overlap", 32'(overlap), 32'd0);
        check("clean_done", 32'(done), 32'd1);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_err", 32'(err_count), 32'd0);
        check("clean_busy", 32'(busy), 32'd0);

        // seed pattern
        run_seed(16'hA5A5);
        check("seed_data3", 32'(data_at3), 32'h0000A5A6);
        check("seed_pass", 32'(pass), 32'd1);

        // corruption of bit 0 at address 5
        corrupt = 1'b1;
        run_seed(16'h0000);
        corrupt = 1'b0;
        check("corr_err", 32'(err_count), 32'd1);
        check("corr_addr", 32'(first_err_addr), 32'h5);
        check("corr_data", 32'(first_err_data), 32'h4);
        check("corr_pass", 32'(pass), 32'd0);
        check("corr_done", 32'(done), 32'd1);

        // start while busy is ignored
        clear_stats();
        @(negedge clk);
        seed = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 500 && read_req !== 1'b1; k++) @(negedge clk);
        check("busy_in_rwait", 32'(read_req), 32'd1);
        seed = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        check("sb_writes", 32'(n_wr), 32'd16);
        check("sb_reads", 32'(n_rd), 32'd16);
        check("sb_pass", 32'(pass), 32'd1);
        check("sb_err", 32'(err_count), 32'd0);

        // third read never acknowledged
        hang_third = 1'b1;
        clear_stats();
        @(negedge clk);
        seed = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef SDRAM_BIST_TIMEOUT_EN
        wait_done(6000);
        check("tmo_timeout", 32'(timeout), 32'd1);
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_err", 32'(err_count), 32'd1);
        check("tmo_pass", 32'(pass), 32'd0);
        check("tmo_reads", 32'(n_rd), 32'd2);
`else
        repeat (5000) @(negedge clk);
        check("hang_busy", 32'(busy), 32'd1);
        check("hang_done", 32'(done), 32'd0);
        check("hang_timeout", 32'(timeout), 32'd0);
`endif
        hang_third = 1'b0;
        sys_rst_n  = 1'b0;
        @(negedge clk);
        sys_rst_n  = 1'b1;

        // reset in the middle of the fill
        clear_stats();
        @(negedge clk);
        seed = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 500 && n_wr < 5; k++) @(negedge clk);
        check("mid_we_before", 32'(write_en), 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_strobes", {30'd0, write_en, write_latch_address}, 32'd0);
        check("mid_addr_data", {address[15:0], data_in}, 32'd0);
        begin
            int held;
            held = n_wr;
            repeat (4) @(negedge clk);
            check("mid_no_strobe", 32'(n_wr), 32'(held));
        end
        sys_rst_n = 1'b1;
        run_seed(16'h0000);
        check("after_rst_writes", 32'(n_wr), 32'd16);
        check("after_rst_pass", 32'(pass), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
